// File: rtl/pll_rst_ctrl_if.sv
// rtl/pll_rst_ctrl_if.sv - PLL lock/reset and core reset request signal bundle
interface pll_rst_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             pll_lock;
   logic             sw_rst;
   logic             pll_reset;
   logic             core_rst_n;
   logic             ready;
   logic [CNT_W-1:0] relock_cnt;

   // master: the sequencer; slave: the PLL/software side
   modport master (
      input  pll_lock,
      input  sw_rst,
      output pll_reset,
      output core_rst_n,
      output ready,
      output relock_cnt
   );

   modport slave (
      output pll_lock,
      output sw_rst,
      input  pll_reset,
      input  core_rst_n,
      input  ready,
      input  relock_cnt
   );
endinterface

// File: rtl/pll_rst_ctrl.sv
// rtl/pll_rst_ctrl.sv - PLL reset sequencer and lock qualifier; optional lock timeout retry via PLL_RST_TIMEOUT_EN
module pll_rst_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   pll_rst_ctrl_if.master       bus
);

   localparam int MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
   localparam int CW      = $clog2(MAX_CYC);

   localparam logic [CW-1:0]    RST_LAST   = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0]    STB_LAST   = CW'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RELOCK_MAX = '1;
`ifdef PLL_RST_TIMEOUT_EN
   localparam logic [CW-1:0]    TO_LAST    = CW'(LOCK_TIMEOUT - 1);
`else
   localparam logic [CW-1:0]    CNT_MAX    = '1;
`endif

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] relock_q, relock_d;
   logic             relock_inc;
   logic             lock_m, lock_s;
   logic             pll_reset_q, core_rst_n_q, ready_q;

   assign bus.pll_reset  = pll_reset_q;
   assign bus.core_rst_n = core_rst_n_q;
   assign bus.ready      = ready_q;
   assign bus.relock_cnt = relock_q;

   // Two-flop synchronizer for the asynchronous PLL lock output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= bus.pll_lock;
         lock_s <= lock_m;
      end
   end

   // State, counter and registered outputs; outputs follow the next state so they change on the transition edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= PLL_RST;
         cnt_q        <= '0;
         relock_q     <= '0;
         pll_reset_q  <= 1'b1;
         core_rst_n_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         relock_q     <= relock_d;
         pll_reset_q  <= (state_d == PLL_RST);
         core_rst_n_q <= (state_d == RUN);
         ready_q      <= (state_d == RUN);
      end
   end

   // Next-state logic; software request outranks lock loss and timeout so it never bumps relock_cnt
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      relock_inc = 1'b0;
      case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (bus.sw_rst) begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end else if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end
`ifdef PLL_RST_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               state_d    = PLL_RST;
               cnt_d      = '0;
               relock_inc = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            // No timeout: the counter is unused here, so hold it at the top instead of wrapping
            else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         STABLE: begin
            if (bus.sw_rst) begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end else if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (bus.sw_rst) begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end else if (!lock_s) begin
               state_d    = PLL_RST;
               cnt_d      = '0;
               relock_inc = 1'b1;
            end
         end
         default: begin
            state_d = PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // Saturating count of involuntary re-sequences
   always_comb begin
      relock_d = relock_q;
      if (relock_inc && (relock_q != RELOCK_MAX)) begin
         relock_d = relock_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// tb/tb_pll_rst_ctrl.sv - directed/randomized self-checking bench for pll_rst_ctrl
module tb_pll_rst_ctrl;
   localparam int R    = 4;
   localparam int S    = 8;
   localparam int T    = 32;
   localparam int CW   = 2;
   localparam int RMAX = (1 << CW) - 1;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   exp_relock = 0;

   pll_rst_ctrl_if #(.CNT_W(CW)) bus ();

   pll_rst_ctrl #(
      .RST_CYCLES    (R),
      .STABLE_CYCLES (S),
      .LOCK_TIMEOUT  (T),
      .CNT_W         (CW)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise lock now; core reset must release exactly S+3 edges later
   task automatic run_lock_up(input string tag);
      bus.pll_lock = 1'b1;
      for (int k = 1; k <= S + 3; k++) begin
         @(negedge clk);
         check({tag, "_core"},  32'(bus.core_rst_n), 32'(k == S + 3));
         check({tag, "_ready"}, 32'(bus.ready),      32'(k == S + 3));
         check({tag, "_prst"},  32'(bus.pll_reset),  32'd0);
      end
   endtask

   // Drop lock while running: reaction on the 3rd edge, then an R-cycle PLL reset pulse
   task automatic lock_loss(input string tag, input bit recover);
      int prev;
      prev = exp_relock;
      exp_relock = (exp_relock < RMAX) ? exp_relock + 1 : RMAX;
      bus.pll_lock = 1'b0;
      for (int k = 1; k <= 3 + R; k++) begin
         @(negedge clk);
         check({tag, "_core"},   32'(bus.core_rst_n), 32'(k < 3));
         check({tag, "_prst"},   32'(bus.pll_reset),  32'(k >= 3 && k < 3 + R));
         check({tag, "_relock"}, 32'(bus.relock_cnt), 32'((k < 3) ? prev : exp_relock));
      end
      if (recover) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_lock_up({tag, "_up"});
      end
   endtask

   initial begin
      int m;
      int g;
      bus.pll_lock = 1'b0;
      bus.sw_rst   = 1'b0;
      resetn       = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_prst",   32'(bus.pll_reset),  32'd1);
      check("rst_core",   32'(bus.core_rst_n), 32'd0);
      check("rst_ready",  32'(bus.ready),      32'd0);
      check("rst_relock", 32'(bus.relock_cnt), 32'd0);

      resetn = 1'b1;
      for (int k = 1; k <= R; k++) begin
         @(negedge clk);
         check("pwr_prst", 32'(bus.pll_reset),  32'(k < R));
         check("pwr_core", 32'(bus.core_rst_n), 32'd0);
      end
      repeat ($urandom_range(0, 8)) @(negedge clk);
      run_lock_up("pwr");
      check("pwr_relock", 32'(bus.relock_cnt), 32'd0);

      lock_loss("loss1", 1'b1);
      lock_loss("loss2", 1'b1);

      // Software request coincident with lock fall; a second request during PLL_RST is ignored
      bus.sw_rst   = 1'b1;
      bus.pll_lock = 1'b0;
      for (int k = 1; k <= R + 4; k++) begin
         @(negedge clk);
         check("sw_prst",   32'(bus.pll_reset),  32'(k <= R));
         check("sw_core",   32'(bus.core_rst_n), 32'd0);
         check("sw_ready",  32'(bus.ready),      32'd0);
         check("sw_relock", 32'(bus.relock_cnt), 32'(exp_relock));
         bus.sw_rst = (k == 2);
      end

      // Lock drops during qualification: no PLL reset, qualification restarts
      bus.pll_lock = 1'b1;
      m = $urandom_range(3, S);
      for (int k = 1; k <= m; k++) begin
         @(negedge clk);
         check("stb_core", 32'(bus.core_rst_n), 32'd0);
         check("stb_prst", 32'(bus.pll_reset),  32'd0);
      end
      bus.pll_lock = 1'b0;
      g = $urandom_range(2, 5);
      for (int k = 1; k <= g + 3; k++) begin
         @(negedge clk);
         check("drop_core",   32'(bus.core_rst_n), 32'd0);
         check("drop_prst",   32'(bus.pll_reset),  32'd0);
         check("drop_relock", 32'(bus.relock_cnt), 32'(exp_relock));
         if (k == g) bus.pll_lock = 1'b1;
         if (k == g) break;
      end
      run_lock_up("restb");

      lock_loss("loss3", 1'b1);
      lock_loss("loss4", 1'b0);

      // Lock held low in WAIT_LOCK
      for (int k = 1; k <= 2 * (T + R); k++) begin
         @(negedge clk);
`ifdef PLL_RST_TIMEOUT_EN
         check("wait_prst", 32'(bus.pll_reset), 32'((k % (T + R)) >= T));
`else
         check("wait_prst", 32'(bus.pll_reset), 32'd0);
`endif
         check("wait_relock", 32'(bus.relock_cnt), 32'(exp_relock));
      end

      run_lock_up("final");

      // Asynchronous reset in RUN takes effect before the next edge
      #2;
      resetn = 1'b0;
      exp_relock = 0;
      #1;
      check("arst_prst",   32'(bus.pll_reset),  32'd1);
      check("arst_core",   32'(bus.core_rst_n), 32'd0);
      check("arst_ready",  32'(bus.ready),      32'd0);
      check("arst_relock", 32'(bus.relock_cnt), 32'(exp_relock));
      @(negedge clk);
      resetn = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
